// File: rtl/imem_ctrl.sv
// Writable instruction memory with a valid/ready fetch port and a registered one-cycle read.
// Self-initialises to NOP after reset; define IMEM_FAULT_EN to flag misaligned/out-of-range fetches.
module imem_ctrl #(
  parameter int          DEPTH = 64,
  parameter int          AW    = $clog2(DEPTH),
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_ins,
  output logic          rsp_err,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  output logic          busy
);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state;
  logic [AW-1:0] init_idx;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          in_range;
  logic          prog_ok;
  logic          fault;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;

  assign rd_idx    = req_addr[AW+1:2];
  assign in_range  = {2'b00, req_addr[31:2]} < 32'(DEPTH);
  assign prog_ok   = 32'(prog_addr) < 32'(DEPTH);
  assign req_ready = (state == RUN) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

`ifdef IMEM_FAULT_EN
  assign fault   = (req_addr[1:0] != 2'b00) || !in_range;
  assign rd_word = fault ? 32'h0 : mem[rd_idx];
`else
  // Byte offset is ignored: a misaligned fetch reads its aligned word.
  logic unused_offset;
  assign unused_offset = ^req_addr[1:0];
  assign fault         = 1'b0;
  assign rd_word       = in_range ? mem[rd_idx] : NOP;
`endif

  // Contents are never reset; INIT is the only thing that clears them.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[init_idx] <= NOP;
    end else if (prog_we && prog_ok) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      init_idx  <= '0;
      busy      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_ins   <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == INIT) begin
        if (init_idx == AW'(DEPTH - 1)) begin
          state <= RUN;
          busy  <= 1'b0;
        end else begin
          init_idx <= init_idx + AW'(1);
        end
      end

      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_ins   <= rd_word;
        rsp_err   <= fault;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/imem_ctrl.md
# imem_ctrl

Parametrised, writable instruction memory for the RISC-V core that replaces the fixed combinational program ROM. It holds `DEPTH` 32-bit words, answers fetches through a valid/ready request/response handshake with a registered one-cycle read, and accepts program loading through a write port. After every reset it initialises itself to `addi x0,x0,0` (NOP, 32'h00000013). It sits between the fetch stage and the boot/debug loader.

## Interface
- `DEPTH`, 64: number of 32-bit instruction words; legal range is 2 to 4096, and the value need not be a power of two.
- `AW`, `$clog2(DEPTH)`: word-index width. This is derived and must not be overridden.
- `NOP`, 32'h00000013: fill value used at init and for fetches outside the memory range.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid` in 1: fetch request is valid.
- `req_ready` out 1: block can accept a fetch request.
- `req_addr` in 32: byte address of the fetch.
- `rsp_valid` out 1: response is valid.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_ins` out 32: fetched instruction word.
- `rsp_err` out 1: fetch fault (see Configuration).
- `prog_we` in 1: program-word write strobe.
- `prog_addr` in AW: word index to write.
- `prog_data` in 32: word to write.
- `busy` out 1: high while initialisation is in progress.

## Operation
- The state machine has two states, INIT and RUN.
- INIT:
  - A counter `init_idx` steps from 0 to DEPTH-1 and writes `NOP` to one word per cycle.
  - `busy`=1 and `req_ready`=0.
  - `prog_we` is ignored.
  - When the counter reaches DEPTH-1, that final word is written and the state moves to RUN on the next cycle.
- RUN:
  - `busy`=0.
  - `req_ready` = `!rsp_valid || rsp_ready`, which makes the output a one-entry register with pass-through on drain.
- Fetch acceptance occurs when `req_valid && req_ready`. In that case:
  - The word index is `req_addr[AW+1:2]`.
  - If `req_addr[31:2] < DEPTH`, `rsp_ins` is loaded with that memory word on the next edge.
  - Otherwise the fetch is out of range and is handled as described under Configuration.
  - `rsp_valid` is set to 1.
- Response hold:
  - While `rsp_valid && !rsp_ready`, `rsp_ins` and `rsp_err` hold stable and no new request is accepted.
  - On `rsp_ready` with no new accept, `rsp_valid` goes to 0 on the next edge.
- Programming:
  - In RUN, `prog_we` writes `prog_data` to `mem[prog_addr]` on the edge.
  - If `prog_addr >= DEPTH`, the write is dropped.
  - Writes never stall fetches.
- Simultaneous write and fetch of the same word: read-before-write applies, so the fetch returns the old word and the next fetch returns the new one.

## Timing
- Reset values:
  - state=INIT, `init_idx`=0
  - `req_ready`=0, `busy`=1
  - `rsp_valid`=0, `rsp_ins`=32'h0, `rsp_err`=0
- Initialisation takes exactly DEPTH cycles after `rst` deasserts. `busy` falls and `req_ready` rises in cycle DEPTH (0-based).
- Fetch latency is 1 cycle: a request accepted at edge n gives `rsp_valid`=1 after edge n.
- Throughput is 1 fetch/cycle while `rsp_ready`=1.
- Reset mid-operation:
  - Any pending response is discarded immediately (`rsp_valid`→0 asynchronously).
  - INIT restarts, and all programmed contents are overwritten with NOP.
- Memory contents are not asynchronously reset. Only INIT clears them.

## Configuration
- Macro: `IMEM_FAULT_EN`.
- Defined:
  - Misaligned fetches (`req_addr[1:0]!=0`) and out-of-range fetches return `rsp_ins`=32'h0 with `rsp_err`=1.
  - Valid fetches return `rsp_err`=0.
- Undefined:
  - `rsp_err` is tied to 0.
  - `req_addr[1:0]` is ignored, so a misaligned fetch returns the word at its aligned address.
  - Out-of-range fetches return `NOP`.

## Test plan
1. **Reset and init, DEPTH=64.** Deassert `rst` → `busy`=1 and `req_ready`=0 for exactly 64 cycles. A fetch of addr 0x0 then returns 32'h00000013 with `rsp_err`=0.
2. **Load and fetch a program.**
   - Write words 0..6 = 04002083, 00008133, 000001b3, 002181b3, fff08093, fe104ce3, 08302023.
   - Fetch byte addresses 0x00–0x18 back-to-back with `rsp_ready`=1.
   - Expect 7 consecutive responses, one per cycle, in that order.
3. **Backpressure.** Hold `rsp_ready`=0 for 3 cycles after a fetch of 0x0C → `rsp_ins`=002181b3 stays stable and `req_ready`=0. Release → the next request is accepted the same cycle.
4. **Write/fetch collision.** In the same cycle, write word 3=0xDEADBEEF and fetch 0x0C → returns 002181b3. Fetch 0x0C again → returns DEADBEEF.
5. **Faults.**
   - Fetch 0x102 (out of range, DEPTH=64) and 0x06 (misaligned).
   - With `IMEM_FAULT_EN`: each returns `rsp_ins`=0 with `rsp_err`=1.
   - Without it: 0x102 returns 00000013, 0x06 returns word 1 (00008133), and `rsp_err`=0 for both.
6. **Reset mid-stream.** Assert `rst` while `rsp_valid`=1 → `rsp_valid` drops immediately, INIT reruns, and a fetch of 0x00 afterwards returns 00000013.
